// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request front-end.
// Used by the controller top and its response buffer.
package ct_spsram_ctrl_pkg;

   localparam int ADDR_WIDTH_DEF = 13;
   localparam int DATA_WIDTH_DEF = 128;
   localparam int RSP_DEPTH      = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Circular pointer step for a buffer whose depth is not a power of two
   function automatic logic [1:0] rsp_ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'(RSP_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// Three-entry in-order buffer holding SRAM read data until the consumer takes it.
// Storage is cleared on reset so the head reads as zero while empty.
module ct_spsram_ctrl_rsp_fifo
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            cnt,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
   logic [1:0]            rd_ptr;
   logic [1:0]            wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop    = pop && (cnt != 2'd0);
   assign do_push   = push && ((cnt != 2'(RSP_DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= rsp_ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= rsp_ptr_inc(rd_ptr);
         end
         cnt <= cnt + 2'(do_push) - 2'(do_pop);
      end
   end

endmodule

// File: rtl/ct_spsram_8192x128_ctrl.sv
// Request front-end for the 8192x128 single-port SRAM: zero-fills the array after
// reset, then turns valid/ready requests into SRAM cycles and buffers read data.
module ct_spsram_8192x128_ctrl
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 8192,
   parameter int INIT_EN    = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_d,
   output logic [DATA_WIDTH-1:0] sram_wen,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   state_e                state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  rd_pend;
   logic [1:0]            fifo_cnt;
   logic                  req_hs;

   // A pending read counts against buffer space so an accepted read always has a slot
   assign req_rdy   = (state == RUN) && ((3'(rd_pend) + 3'(fifo_cnt)) < 3'(RSP_DEPTH));
   assign req_hs    = req_vld && req_rdy;
   assign init_done = (state == RUN);
   assign rsp_vld   = (fifo_cnt != 2'd0);

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state    <= IDLE;
         init_cnt <= '0;
         rd_pend  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= (INIT_EN != 0) ? INIT : RUN;
               init_cnt <= '0;
            end
            INIT: begin
               if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state    <= RUN;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + ADDR_WIDTH'(1);
               end
            end
            RUN:     state <= RUN;
            default: state <= IDLE;
         endcase
         rd_pend <= req_hs && !req_wr;
      end
   end

   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = '0;
      sram_d    = '0;
      if (state == INIT) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = init_cnt;
      end else if (req_hs) begin
         sram_cen = 1'b0;
         sram_a   = req_addr;
         if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_d    = req_wdata;
         end
      end
   end

   // Q is valid the cycle after the read edge, which is exactly when rd_pend is high
   ct_spsram_ctrl_rsp_fifo #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rsp_fifo (
      .clk       (forever_cpuclk),
      .rst_b     (cpurst_b),
      .push      (rd_pend),
      .push_data (sram_q),
      .pop       (rsp_vld && rsp_rdy),
      .cnt       (fifo_cnt),
      .head_data (rsp_data)
   );

endmodule

// File: tb/tb_ct_spsram_8192x128_ctrl.sv
// Scoreboard bench for the SRAM front-end: behavioural SRAM, queued expected read
// data checked by an independent response monitor, plus directed timing checks.
module tb_ct_spsram_8192x128_ctrl;

   localparam int AW    = 13;
   localparam int DW    = 128;
   localparam int DEPTH = 8192;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] req_wmask;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_data;
   logic          init_done;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_q;

   logic          rst2_b;
   logic          req2_vld;
   logic          req2_rdy;
   logic [AW-1:0] req2_addr;
   logic          rsp2_vld;
   logic [DW-1:0] rsp2_data;
   logic          init2_done;
   logic [AW-1:0] sram2_a;
   logic          sram2_cen;
   logic          sram2_gwen;
   logic [DW-1:0] sram2_d;
   logic [DW-1:0] sram2_wen;
   logic [DW-1:0] sram2_q;

   int            vectors_applied = 0;
   int            miscompares     = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   ct_spsram_8192x128_ctrl #(.INIT_EN(1)) u_dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_b),
      .req_vld        (req_vld),
      .req_rdy        (req_rdy),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_wmask      (req_wmask),
      .rsp_vld        (rsp_vld),
      .rsp_rdy        (rsp_rdy),
      .rsp_data       (rsp_data),
      .init_done      (init_done),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_d         (sram_d),
      .sram_wen       (sram_wen),
      .sram_q         (sram_q)
   );

   ct_spsram_8192x128_ctrl #(.INIT_EN(0)) u_dut_noinit (
      .forever_cpuclk (clk),
      .cpurst_b       (rst2_b),
      .req_vld        (req2_vld),
      .req_rdy        (req2_rdy),
      .req_wr         (1'b0),
      .req_addr       (req2_addr),
      .req_wdata      ('0),
      .req_wmask      ('0),
      .rsp_vld        (rsp2_vld),
      .rsp_rdy        (1'b1),
      .rsp_data       (rsp2_data),
      .init_done      (init2_done),
      .sram_a         (sram2_a),
      .sram_cen       (sram2_cen),
      .sram_gwen      (sram2_gwen),
      .sram_d         (sram2_d),
      .sram_wen       (sram2_wen),
      .sram_q         (sram2_q)
   );

   // Behavioural SRAM; never-written words read back as a garbage pattern
   logic [DW-1:0]    sram_mem [DEPTH];
   logic [DEPTH-1:0] sram_written = '0;

   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) begin
            sram_mem[sram_a]     <= ((sram_written[sram_a] ? sram_mem[sram_a] : {4{32'hBADC0DE5}}) & sram_wen)
                                    | (sram_d & ~sram_wen);
            sram_written[sram_a] <= 1'b1;
         end else begin
            sram_q <= sram_written[sram_a] ? sram_mem[sram_a] : {4{32'hBADC0DE5}};
         end
      end
   end

   always @(posedge clk) begin
      if (!sram2_cen && sram2_gwen) begin
         sram2_q <= {8{3'b000, sram2_a}};
      end
   end

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors_applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every presented-and-taken response must match the queue head
   always @(negedge clk) begin
      if (rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL unexpected_rsp: got rsp_data %h, required no response", rsp_data);
         end else begin
            check_output("rsp_data", rsp_data, exp_q.pop_front());
         end
      end
   end

   task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] wmask,
                                 input logic [DW-1:0] exp);
      int n;
      req_vld   = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      n = 0;
      while (req_rdy !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         vectors_applied++;
         miscompares++;
         $display("[TB] FAIL req_accept_timeout: got req_rdy %b after %0d cycles, required 1", req_rdy, n);
      end else if (!wr) begin
         exp_q.push_back(exp);
      end
      tick();
      req_vld = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int            bad;
      int            n;
      int            accepted;
      logic [DW-1:0] held;

      rst_b     = 1'b0;
      rst2_b    = 1'b0;
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      rsp_rdy   = 1'b1;
      req2_vld  = 1'b0;
      req2_addr = '0;
      repeat (3) tick();

      check_output("rst_req_rdy", req_rdy, 0);
      check_output("rst_rsp_vld", rsp_vld, 0);
      check_output("rst_rsp_data", rsp_data, 0);
      check_output("rst_init_done", init_done, 0);
      check_output("rst_sram_cen", sram_cen, 1);
      check_output("rst_sram_gwen", sram_gwen, 1);
      check_output("rst_sram_wen", sram_wen, {DW{1'b1}});
      check_output("rst_sram_a", sram_a, 0);
      check_output("rst_sram_d", sram_d, 0);
      check_output("rst_noinit_done", init2_done, 0);

      // Release reset; the next edge is E0 and the zero-fill sweep follows it
      rst_b = 1'b1;
      tick();
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 ||
             sram_a !== AW'(i) || init_done !== 1'b0 || req_rdy !== 1'b0) begin
            bad++;
         end
         tick();
      end
      check_output("init_sweep_bad_cycles", bad, 0);
      check_output("init_done_after_sweep", init_done, 1);
      check_output("req_rdy_after_sweep", req_rdy, 1);
      bad = 0;
      repeat (5) begin
         if (sram_cen !== 1'b1) bad++;
         tick();
      end
      check_output("idle_after_init_bad_cycles", bad, 0);

      // Masked write of all-ones to addr 5, then read it back
      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 13'd5;
      req_wdata = {DW{1'b1}};
      req_wmask = {112'b0, 16'hFFFF};
      #1;
      check_output("wr_req_rdy", req_rdy, 1);
      check_output("wr_sram_cen", sram_cen, 0);
      check_output("wr_sram_gwen", sram_gwen, 0);
      check_output("wr_sram_wen", sram_wen, {{112{1'b1}}, 16'h0000});
      check_output("wr_sram_a", sram_a, 5);
      check_output("wr_sram_d", sram_d, {DW{1'b1}});
      tick();
      req_wr = 1'b0;
      #1;
      check_output("rd_sram_cen", sram_cen, 0);
      check_output("rd_sram_gwen", sram_gwen, 1);
      check_output("rd_sram_wen", sram_wen, {DW{1'b1}});
      exp_q.push_back({112'b0, 16'hFFFF});
      tick();
      req_vld = 1'b0;
      check_output("rd_rsp_vld_n_plus_1", rsp_vld, 0);
      tick();
      check_output("rd_rsp_vld_n_plus_2", rsp_vld, 1);
      tick();

      // Fill addr 0..7 with distinct words, then read them back-to-back
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, AW'(i), {4{32'hC0DE_0000 + 32'(i)}}, {DW{1'b1}}, '0);
      end
      bad = 0;
      for (int j = 0; j < 10; j++) begin
         if (j < 8) begin
            req_vld  = 1'b1;
            req_wr   = 1'b0;
            req_addr = AW'(j);
            if (req_rdy !== 1'b1) bad++;
            exp_q.push_back({4{32'hC0DE_0000 + 32'(j)}});
         end else begin
            req_vld = 1'b0;
         end
         if (j >= 2 && rsp_vld !== 1'b1) bad++;
         tick();
      end
      check_output("b2b_bad_cycles", bad, 0);
      check_output("b2b_drained_rsp_vld", rsp_vld, 0);

      // Backpressure: only three reads fit while the consumer stalls
      rsp_rdy  = 1'b0;
      accepted = 0;
      for (int j = 0; j < 6; j++) begin
         req_vld  = 1'b1;
         req_wr   = 1'b0;
         req_addr = AW'(accepted);
         if (req_rdy === 1'b1) begin
            exp_q.push_back({4{32'hC0DE_0000 + 32'(accepted)}});
            accepted++;
         end
         tick();
      end
      req_vld = 1'b0;
      check_output("bp_accepted", accepted, 3);
      check_output("bp_req_rdy", req_rdy, 0);
      held = rsp_data;
      bad  = 0;
      repeat (4) begin
         if (rsp_data !== held || rsp_vld !== 1'b1) bad++;
         tick();
      end
      check_output("bp_hold_bad_cycles", bad, 0);
      check_output("bp_head_data", held, {4{32'hC0DE_0000}});
      rsp_rdy = 1'b1;
      repeat (4) tick();
      check_output("bp_drain_req_rdy", req_rdy, 1);
      check_output("bp_drain_rsp_vld", rsp_vld, 0);
      check_output("bp_drain_queue", exp_q.size(), 0);

      // Two reads in flight, then a one-cycle reset discards both
      rsp_rdy  = 1'b0;
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 13'd1;
      tick();
      req_addr = 13'd2;
      tick();
      req_vld = 1'b0;
      rst_b   = 1'b0;
      tick();
      check_output("midrst_rsp_vld", rsp_vld, 0);
      check_output("midrst_rsp_data", rsp_data, 0);
      check_output("midrst_init_done", init_done, 0);
      check_output("midrst_req_rdy", req_rdy, 0);
      check_output("midrst_sram_cen", sram_cen, 1);
      rsp_rdy = 1'b1;
      rst_b   = 1'b1;
      n = 0;
      while (init_done !== 1'b1 && n < 9000) begin
         tick();
         n++;
      end
      check_output("rerun_init_cycles", n, DEPTH + 1);
      apply_stimulus(1'b0, 13'd1, '0, '0, '0);
      apply_stimulus(1'b0, 13'd5, '0, '0, '0);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check_output("final_queue_empty", exp_q.size(), 0);
      repeat (3) tick();

      // Instance without the zero-fill is usable right after E0
      rst2_b = 1'b1;
      tick();
      check_output("noinit_init_done", init2_done, 1);
      check_output("noinit_req_rdy", req2_rdy, 1);
      req2_vld  = 1'b1;
      req2_addr = 13'd77;
      #1;
      check_output("noinit_sram_cen", sram2_cen, 0);
      tick();
      req2_vld = 1'b0;
      check_output("noinit_rsp_vld_n_plus_1", rsp2_vld, 0);
      tick();
      check_output("noinit_rsp_vld_n_plus_2", rsp2_vld, 1);
      check_output("noinit_rsp_data", rsp2_data, {8{16'h004D}});
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
